// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand fetch with bypassing, ALU operand/result registers and
// register-file retire for a combinational ALU; flags divide-by-zero on the way out.
module alu_operand_stage #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_op,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [REG_AW-1:0] in_rs1,
   input  logic [REG_AW-1:0] in_rs2,
   input  logic              in_imm_en,
   input  logic [DATA_W-1:0] in_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [REG_AW-1:0] out_rd,
   output logic [DATA_W-1:0] out_data,
   output logic              out_divz
);
   logic              r_ex_valid, r_out_valid, r_out_divz;
   logic [REG_AW-1:0] r_ex_rd, r_out_rd;
   logic [1:0]        r_alu_op;
   logic [DATA_W-1:0] r_alu_a, r_alu_b, r_out_data;
   logic [DATA_W-1:0] r_rf [NREG];
   logic              w_w_adv, w_e_adv, w_accept, w_divz;
   logic [DATA_W-1:0] w_e_val, w_rs1_val, w_rs2_val;

   assign w_w_adv  = !r_out_valid || out_ready;
   assign w_e_adv  = !r_ex_valid || w_w_adv;
   assign in_ready = w_e_adv && !flush;
   assign w_accept = in_valid && in_ready;
   assign w_divz   = r_alu_op == 2'b11 && r_alu_b == '0;
   assign w_e_val  = w_divz ? '0 : alu_result;

   // Youngest producer wins: E stage, then W stage, then the register file.
   assign w_rs1_val = in_rs1 == '0 ? '0 :
                      (r_ex_valid && r_ex_rd == in_rs1) ? w_e_val :
                      (r_out_valid && r_out_rd == in_rs1) ? r_out_data : r_rf[in_rs1];
   assign w_rs2_val = in_imm_en ? in_imm : in_rs2 == '0 ? '0 :
                      (r_ex_valid && r_ex_rd == in_rs2) ? w_e_val :
                      (r_out_valid && r_out_rd == in_rs2) ? r_out_data : r_rf[in_rs2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_valid  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_divz  <= 1'b0;
         r_ex_rd     <= '0;
         r_out_rd    <= '0;
         r_alu_op    <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_out_data  <= '0;
         for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      end else if (flush) begin
         r_ex_valid  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_e_adv) begin
            r_ex_valid <= w_accept;
            if (w_accept) begin
               r_alu_a  <= w_rs1_val;
               r_alu_b  <= w_rs2_val;
               r_alu_op <= in_op;
               r_ex_rd  <= in_rd;
            end
         end
         if (w_w_adv) begin
            r_out_valid <= r_ex_valid;
            if (r_ex_valid) begin
               r_out_data <= w_e_val;
               r_out_divz <= w_divz;
               r_out_rd   <= r_ex_rd;
            end
         end
         if (r_out_valid && out_ready && r_out_rd != '0) r_rf[r_out_rd] <= r_out_data;
      end
   end

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_op    = r_alu_op;
   assign out_valid = r_out_valid;
   assign out_rd    = r_out_rd;
   assign out_data  = r_out_data;
   assign out_divz  = r_out_divz;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed scenarios plus randomized traffic checked against a
// program-order model (committed registers + queue of in-flight results).
module tb_alu_operand_stage;
   logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
   logic        in_valid = 1'b0, in_ready, in_imm_en = 1'b0, out_ready = 1'b1;
   logic [1:0]  in_op = '0, alu_op;
   logic [3:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0, out_rd;
   logic [31:0] in_imm = '0, alu_a, alu_b, alu_result, out_data;
   logic        out_valid, out_divz;

   int checks = 0, errors = 0;

   typedef struct {
      logic [3:0]  rd;
      logic [1:0]  op;
      logic [31:0] a, b, data;
      logic        divz;
      bit          inw;
   } ent_t;
   ent_t        q[$];
   logic [31:0] m_rf [16];

   alu_operand_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_imm_en(in_imm_en), .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .alu_result(alu_result), .out_valid(out_valid),
      .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data), .out_divz(out_divz)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] arith(logic [1:0] op, logic [31:0] a, logic [31:0] b);
      if (op == 2'd0) return a + b;
      if (op == 2'd1) return a - b;
      if (op == 2'd2) return a * b;
      return (b == 0) ? 32'd0 : a / b;
   endfunction

   // Behavioural ALU; a divide by zero yields garbage the stage must ignore.
   always_comb alu_result = (alu_op == 2'd3 && alu_b == 0) ? 32'hDEADBEEF : arith(alu_op, alu_a, alu_b);

   function automatic logic [31:0] reg_val(logic [3:0] r);
      if (r == 0) return 32'd0;
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].rd == r) return q[i].data;
      return m_rf[r];
   endfunction

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
   endtask

   // Scoreboard cycle: compare DUT against the model, advance the model across one edge.
   task automatic tick(output bit acc);
      bit   w_full, e_full, wadv, exp_rdy;
      ent_t e;
      #1;
      w_full  = q.size() > 0 && q[0].inw;
      e_full  = q.size() > 0 && !q[q.size()-1].inw;
      wadv    = !w_full || out_ready;
      exp_rdy = !flush && (!e_full || wadv);
      acc     = in_valid && in_ready;
      checks++;
      if (in_ready !== exp_rdy) begin errors++; $display("FAIL in_ready got %b exp %b t=%0t", in_ready, exp_rdy, $time); end
      checks++;
      if (out_valid !== w_full) begin errors++; $display("FAIL out_valid got %b exp %b t=%0t", out_valid, w_full, $time); end
      if (w_full) begin
         checks++;
         if (out_data !== q[0].data || out_rd !== q[0].rd || out_divz !== q[0].divz) begin
            errors++;
            $display("FAIL w_stage got rd=%0d data=%h divz=%b exp rd=%0d data=%h divz=%b t=%0t",
                     out_rd, out_data, out_divz, q[0].rd, q[0].data, q[0].divz, $time);
         end
      end
      if (e_full) begin
         e = q[q.size()-1];
         checks++;
         if (alu_a !== e.a || alu_b !== e.b || alu_op !== e.op) begin
            errors++;
            $display("FAIL e_stage got a=%h b=%h op=%0d exp a=%h b=%h op=%0d t=%0t",
                     alu_a, alu_b, alu_op, e.a, e.b, e.op, $time);
         end
      end
      if (flush) q.delete();
      else begin
         if (w_full && out_ready) begin
            if (q[0].rd != 0) m_rf[q[0].rd] = q[0].data;
            void'(q.pop_front());
         end
         if (wadv && q.size() > 0 && !q[0].inw) begin
            e = q[0];
            e.inw = 1'b1;
            q[0] = e;
         end
         if (in_valid && exp_rdy) begin
            e.rd   = in_rd;
            e.op   = in_op;
            e.a    = reg_val(in_rs1);
            e.b    = in_imm_en ? in_imm : reg_val(in_rs2);
            e.divz = in_op == 2'd3 && e.b == 0;
            e.data = arith(e.op, e.a, e.b);
            e.inw  = 1'b0;
            q.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(logic [1:0] op, logic [3:0] rd, logic [3:0] rs1, logic [3:0] rs2,
                        logic ie, logic [31:0] imm, output bit acc);
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_imm_en = ie; in_imm = imm;
      tick(acc);
   endtask

   task automatic idle();
      bit acc;
      in_valid = 1'b0;
      flush = 1'b0;
      tick(acc);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_divz !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl got ov=%b rdy=%b dz=%b exp 0 1 0", out_valid, in_ready, out_divz);
      end
      checks++;
      if (alu_a !== 0 || alu_b !== 0 || alu_op !== 0 || out_data !== 0 || out_rd !== 0) begin
         errors++; $display("FAIL reset_data got a=%h b=%h op=%0d d=%h rd=%0d exp all 0", alu_a, alu_b, alu_op, out_data, out_rd);
      end
   endtask

   task automatic test_dependent_add();
      bit acc;
      out_ready = 1'b1;
      issue(2'd0, 4'd1, 4'd0, 4'd0, 1'b1, 32'd5, acc);
      issue(2'd0, 4'd2, 4'd1, 4'd0, 1'b1, 32'd7, acc);
      checks++;
      if (out_data !== 32'd5) begin errors++; $display("FAIL dep_add1 got %0d exp 5", out_data); end
      idle();
      checks++;
      if (out_data !== 32'd12) begin errors++; $display("FAIL dep_add2 got %0d exp 12", out_data); end
      idle(); idle();
      issue(2'd0, 4'd9, 4'd2, 4'd0, 1'b1, 32'd0, acc);
      idle();
      checks++;
      if (out_data !== 32'd12) begin errors++; $display("FAIL rf_r2 got %0d exp 12", out_data); end
      idle();
   endtask

   task automatic test_arith_chain();
      bit acc;
      int n = 0;
      issue(2'd0, 4'd3, 4'd0, 4'd0, 1'b1, 32'd20, acc); n += int'(acc);
      issue(2'd0, 4'd4, 4'd0, 4'd0, 1'b1, 32'd6, acc);  n += int'(acc);
      issue(2'd1, 4'd5, 4'd3, 4'd4, 1'b0, 32'hFFFF, acc); n += int'(acc);
      issue(2'd2, 4'd6, 4'd5, 4'd4, 1'b0, 32'hFFFF, acc); n += int'(acc);
      checks++;
      if (out_data !== 32'd14) begin errors++; $display("FAIL chain_sub got %0d exp 14", out_data); end
      issue(2'd3, 4'd7, 4'd6, 4'd4, 1'b0, 32'hFFFF, acc); n += int'(acc);
      checks++;
      if (out_data !== 32'd84) begin errors++; $display("FAIL chain_mul got %0d exp 84", out_data); end
      idle();
      checks++;
      if (out_data !== 32'd14) begin errors++; $display("FAIL chain_div got %0d exp 14", out_data); end
      checks++;
      if (n != 5) begin errors++; $display("FAIL chain_accepts got %0d exp 5", n); end
      idle();
   endtask

   task automatic test_divz();
      bit acc;
      issue(2'd3, 4'd8, 4'd3, 4'd0, 1'b1, 32'd0, acc);
      issue(2'd0, 4'd9, 4'd8, 4'd0, 1'b1, 32'd1, acc);
      checks++;
      if (out_data !== 32'd0 || out_divz !== 1'b1) begin
         errors++; $display("FAIL divz got data=%h dz=%b exp 0 1", out_data, out_divz);
      end
      idle();
      checks++;
      if (out_data !== 32'd1 || out_divz !== 1'b0) begin
         errors++; $display("FAIL after_divz got data=%h dz=%b exp 1 0", out_data, out_divz);
      end
      idle();
   endtask

   task automatic test_backpressure();
      bit acc;
      int k = 0;
      logic [31:0] held = '0;
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         issue(2'd0, 4'd10, 4'd10, 4'd0, 1'b1, 32'd100 + 32'(k), acc);
         if (acc) k++;
         if (c == 1) held = out_data;
      end
      #1;
      checks++;
      if (k != 2) begin errors++; $display("FAIL bp_accepts got %0d exp 2", k); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", in_ready); end
      checks++;
      if (out_data !== held || out_data !== 32'd100) begin
         errors++; $display("FAIL bp_stable got %0d exp %0d", out_data, 100);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 5 && k < 3; c++) begin
         issue(2'd0, 4'd10, 4'd10, 4'd0, 1'b1, 32'd100 + 32'(k), acc);
         if (acc) k++;
      end
      repeat (3) idle();
   endtask

   task automatic test_flush();
      bit acc;
      out_ready = 1'b1;
      issue(2'd0, 4'd11, 4'd0, 4'd0, 1'b1, 32'd55, acc);
      issue(2'd0, 4'd12, 4'd0, 4'd0, 1'b1, 32'd66, acc);
      flush = 1'b1;
      in_rd = 4'd13;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", in_ready); end
      tick(acc);
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_outv got %b exp 0", out_valid); end
      idle();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_exv got %b exp 0", out_valid); end
      issue(2'd0, 4'd13, 4'd11, 4'd0, 1'b1, 32'd0, acc);
      issue(2'd0, 4'd14, 4'd12, 4'd0, 1'b1, 32'd1, acc);
      checks++;
      if (out_data !== 32'd0) begin errors++; $display("FAIL flush_r11 got %0d exp 0", out_data); end
      idle();
      checks++;
      if (out_data !== 32'd1) begin errors++; $display("FAIL flush_r12 got %0d exp 1", out_data); end
      idle();
   endtask

   task automatic test_random();
      bit acc;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom % 4) != 0;
         in_op     = 2'($urandom);
         in_rd     = 4'($urandom);
         in_rs1    = 4'($urandom);
         in_rs2    = 4'($urandom);
         in_imm_en = ($urandom % 3) == 0;
         in_imm    = ($urandom % 4 == 0) ? 32'($urandom % 3) : $urandom;
         out_ready = ($urandom % 10) < 7;
         flush     = ($urandom % 20) == 0;
         tick(acc);
      end
      flush = 1'b0;
      out_ready = 1'b1;
      repeat (3) idle();
   endtask

   task automatic test_async_reset();
      bit acc;
      out_ready = 1'b0;
      issue(2'd0, 4'd15, 4'd0, 4'd0, 1'b1, 32'd7, acc);
      issue(2'd0, 4'd1, 4'd15, 4'd0, 1'b1, 32'd3, acc);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_a !== 0) begin
         errors++; $display("FAIL async_rst got ov=%b rdy=%b a=%h exp 0 1 0", out_valid, in_ready, alu_a);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      issue(2'd0, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0, acc);
      idle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd0) begin
         errors++; $display("FAIL rst_rf got ov=%b data=%h exp 1 0", out_valid, out_data);
      end
      idle();
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_dependent_add();
      test_arith_chain();
      test_divz();
      test_backpressure();
      test_flush();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Execute-side operand stage that sits directly upstream of the combinational ALU. It accepts decoded instructions over a valid/ready handshake and reads operands from an internal 16-entry register file with bypassing. It drives the ALU's `a`/`b`/`op` inputs from a pipeline register, captures the ALU `result` into an output register, and retires results back into the register file on downstream handshake. It also detects divide-by-zero, which the combinational ALU cannot flag.

## Interface
- `DATA_W`, 32: datapath width; must match the ALU width.
- `NREG`, 16: register file entries; r0 reads as 0 and is never written.
- `REG_AW`, 4: register index width, log2(NREG).

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `flush`  in  1: synchronous; kills in-flight instructions.
- `in_valid`  in  1: instruction offered.
- `in_ready`  out  1: stage can accept.
- `in_op`  in  2: 00 add, 01 sub, 10 mul, 11 div.
- `in_rd`, `in_rs1`, `in_rs2`  in  REG_AW: destination and source registers.
- `in_imm_en`  in  1: when 1, operand b comes from `in_imm` instead of rs2.
- `in_imm`  in  DATA_W: immediate value.
- `alu_a`, `alu_b`  out  DATA_W: registered operands driven to the ALU.
- `alu_op`  out  2: registered opcode driven to the ALU.
- `alu_result`  in  DATA_W: combinational ALU output.
- `out_valid`  out  1: retired result available.
- `out_ready`  in  1: downstream accepts.
- `out_rd`  out  REG_AW: destination of the retired result.
- `out_data`  out  DATA_W: retired result.
- `out_divz`  out  1: retired op was a divide with b == 0.

## Operation
- The pipeline has two registered stages:
  - E holds `ex_valid`, `alu_a`, `alu_b`, `alu_op`, `ex_rd`.
  - W holds `out_valid`, `out_data`, `out_rd`, `out_divz`.
- Advance conditions:
  - W advances (`w_adv`) when `!out_valid || out_ready`.
  - E advances (`e_adv`) when `!ex_valid || w_adv`.
  - `in_ready = e_adv && !flush`, combinational.
- Accept (`in_valid && in_ready`):
  - E loads the resolved operands, `in_op`, and `in_rd`; `ex_valid` is set to 1.
  - If `e_adv` is true but there is no accept, `ex_valid` is cleared to 0.
- E→W transfer, when `ex_valid && w_adv`:
  - Normally `out_data` ← `alu_result` and `out_divz` ← 0.
  - If `alu_op == 11` and `alu_b == 0`, then `out_data` ← 0 and `out_divz` ← 1; the ALU output is ignored.
  - `out_valid` ← 1.
  - If `w_adv` is true and E is empty, `out_valid` ← 0.
- Retire: `out_valid && out_ready` writes `out_data` into `regfile[out_rd]`, unless `out_rd == 0`.
- Operand resolution is combinational and evaluated per source. The first match wins:
  1. Index 0 → 0.
  2. `ex_valid && ex_rd == rs` → the E-stage value. This is `alu_result`, or 0 for a divide-by-zero.
  3. `out_valid && out_rd == rs` → `out_data`.
  4. `regfile[rs]`.
- `in_imm_en = 1` replaces the b operand with `in_imm`; rs2 is ignored.
- Arithmetic is the ALU's own: results are the low DATA_W bits, with no overflow flag.
- `flush`:
  - On the next edge, `ex_valid` ← 0 and `out_valid` ← 0.
  - There is no register-file write on that edge, even if `out_ready` is high.
  - There is no accept on that edge.
  - `flush` takes priority over every other update.
- Reset values:
  - `ex_valid`, `out_valid`, `out_divz`: 0.
  - `alu_a`, `alu_b`, `out_data`: 0.
  - `alu_op`, `out_rd`, `ex_rd`: 0.
  - All register-file entries: 0.
  - `in_ready` evaluates to 1 once `rst` deasserts.
- Asserting `rst` mid-operation discards all in-flight instructions immediately; there is no partial write.

## Timing
- An instruction accepted at edge N appears on `alu_a`/`alu_b`/`alu_op` after edge N.
- The result is captured at edge N+1, with `out_valid` = 1 after N+1, assuming `out_ready` was high or W was empty.
- The register-file write happens at the first edge with `out_valid && out_ready`.
- Sustained throughput is 1 instruction per cycle while `out_ready` = 1.
- Back-pressure:
  - If `out_ready` = 0 while W is full, W holds its values.
  - E then holds if `ex_valid`, and `in_ready` drops in the same cycle.
  - `out_data`, `out_rd`, and `out_divz` must stay stable while `out_valid && !out_ready`.
- Back-to-back dependents need no stall cycles: forwarding covers distances 1 and 2. Distance ≥ 3 reads the register file, already written.
- A read and a retire-write of the same register on the same edge: the read takes the forwarded W value (priority 3), never the stale register-file value.

## Test plan
- After reset, issue `add r1, r0, imm=5` and `add r2, r1, imm=7` back-to-back with `out_ready` = 1 → `out_data` = 5 then 12. `r2` holds 12.
- Preload `r3` = 20, `r4` = 6. Issue `sub r5, r3, r4`, `mul r6, r5, r4`, `div r7, r6, r4` consecutively → outputs 14, 84, 14 at 1/cycle, with no `in_ready` deassertion.
- Issue `div r8, r3, imm=0` → `out_data` = 0 and `out_divz` = 1; `r8` = 0. A following `add` outputs `out_divz` = 0.
- Hold `out_ready` = 0 for 4 cycles with 3 instructions offered → only 2 accepted, `out_data` stable, `in_ready` = 0. Releasing drains results in order.
- Accept 2 instructions, then pulse `flush` → both `valid`s are 0 next cycle and neither destination register changes. `in_ready` = 0 during the flush cycle.
- Assert `rst` asynchronously between edges with W full → `out_valid` drops immediately and register file reads return 0.
